// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : MISC-V fetch stage: PC, credit-limited imem requests, 2-entry
//            instruction queue, redirect flush. Option: FETCH_ALIGN_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [15:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [15:0]     id_instruction,
   output logic [PC_W-1:0] id_pc
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic            id_misalign
`endif
);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [1:0]      inflight_q, inflight_d;
   logic [1:0]      drop_q, drop_d;
   logic [1:0]      q_count_q, q_count_d;
   logic [15:0]     q_data_q [2];
   logic [15:0]     q_data_d [2];
   logic [PC_W-1:0] q_pc_q [2];
   logic [PC_W-1:0] q_pc_d [2];
   logic [PC_W-1:0] s_pc_q [2];
   logic [PC_W-1:0] s_pc_d [2];
   logic            s_wr_q, s_wr_d;
   logic            s_rd_q, s_rd_d;
   logic            run_q;
   logic            w_halted;

`ifdef FETCH_ALIGN_CHECK_EN
   logic            halt_q, halt_d;
   logic [1:0]      q_mis_q, q_mis_d;
   assign w_halted    = halt_q;
   assign id_misalign = id_valid & q_mis_q[0];
`else
   assign w_halted    = 1'b0;
`endif

   logic w_credit, w_acc, w_rsp, w_discard, w_push, w_pop, w_widx;

   // Credit uses registered counts only, so a same-cycle pop never frees a slot.
   assign w_credit       = (3'(inflight_q) + 3'(q_count_q)) < 3'd2;
   assign imem_req_valid = run_q & ~redirect_valid & ~w_halted & w_credit;
   assign imem_addr      = pc_q;
   assign id_valid       = (q_count_q != 2'd0);
   assign id_instruction = q_data_q[0];
   assign id_pc          = q_pc_q[0];

   assign w_acc     = imem_req_valid & imem_req_ready;
   assign w_rsp     = imem_rsp_valid & (inflight_q != 2'd0);
   assign w_discard = w_rsp & (drop_q != 2'd0);
   assign w_push    = w_rsp & (drop_q == 2'd0);
   assign w_pop     = id_valid & id_ready;
   // Slot 0 is always the head; a push lands behind whatever survives the pop.
   assign w_widx    = w_pop ? (q_count_q == 2'd2) : (q_count_q == 2'd1);

   always_comb begin
      pc_d       = pc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      q_count_d  = q_count_q;
      q_data_d   = q_data_q;
      q_pc_d     = q_pc_q;
      s_pc_d     = s_pc_q;
      s_wr_d     = s_wr_q;
      s_rd_d     = s_rd_q;
`ifdef FETCH_ALIGN_CHECK_EN
      halt_d     = halt_q;
      q_mis_d    = q_mis_q;
`endif
      if (redirect_valid) begin
         // Everything still in flight becomes stale, including this cycle's response.
         inflight_d = inflight_q - {1'b0, w_rsp};
         drop_d     = inflight_q - {1'b0, w_rsp};
         q_count_d  = 2'd0;
         s_wr_d     = 1'b0;
         s_rd_d     = 1'b0;
         pc_d       = redirect_pc & ~PC_W'(1);
`ifdef FETCH_ALIGN_CHECK_EN
         halt_d     = redirect_pc[0];
         if (redirect_pc[0]) begin
            q_count_d   = 2'd1;
            q_data_d[0] = 16'h0000;
            q_pc_d[0]   = redirect_pc;
            q_mis_d     = 2'b01;
         end
`endif
      end else begin
         if (w_acc) begin
            pc_d           = pc_q + PC_W'(2);
            s_pc_d[s_wr_q] = pc_q;
            s_wr_d         = ~s_wr_q;
         end
         inflight_d = inflight_q + {1'b0, w_acc} - {1'b0, w_rsp};
         if (w_discard) begin
            drop_d = drop_q - 2'd1;
         end
         if (w_pop) begin
            q_data_d[0] = q_data_q[1];
            q_pc_d[0]   = q_pc_q[1];
`ifdef FETCH_ALIGN_CHECK_EN
            q_mis_d[0]  = q_mis_q[1];
`endif
         end
         if (w_push) begin
            q_data_d[w_widx] = imem_rsp_data;
            q_pc_d[w_widx]   = s_pc_q[s_rd_q];
`ifdef FETCH_ALIGN_CHECK_EN
            q_mis_d[w_widx]  = 1'b0;
`endif
            s_rd_d           = ~s_rd_q;
         end
         q_count_d = q_count_q + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         inflight_q <= 2'd0;
         drop_q     <= 2'd0;
         q_count_q  <= 2'd0;
         q_data_q   <= '{default: '0};
         q_pc_q     <= '{default: '0};
         s_pc_q     <= '{default: '0};
         s_wr_q     <= 1'b0;
         s_rd_q     <= 1'b0;
         run_q      <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         halt_q     <= 1'b0;
         q_mis_q    <= 2'b00;
`endif
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         q_count_q  <= q_count_d;
         q_data_q   <= q_data_d;
         q_pc_q     <= q_pc_d;
         s_pc_q     <= s_pc_d;
         s_wr_q     <= s_wr_d;
         s_rd_q     <= s_rd_d;
         run_q      <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
         halt_q     <= halt_d;
         q_mis_q    <= q_mis_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit with an in-order memory model
//            and a program-order reference. Option: FETCH_ALIGN_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

   localparam logic [15:0] C_RESET_PC = 16'h0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid, imem_req_ready;
   logic [15:0] imem_addr;
   logic        imem_rsp_valid;
   logic [15:0] imem_rsp_data;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        id_valid, id_ready;
   logic [15:0] id_instruction, id_pc;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        id_misalign;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.PC_W(16), .RESET_PC(C_RESET_PC)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instruction (id_instruction),
      .id_pc          (id_pc)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .id_misalign    (id_misalign)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int last_due = 0;

   // Memory: pending accepted requests in order, each with its response cycle.
   logic [15:0] mq_addr [$];
   int          mq_due  [$];

   // Reference: next address expected at decode and next address to be fetched.
   logic [15:0] m_id_pc, m_fetch, m_mis_pc;
   bit          m_mis_pending, m_halt;

   bit          obs_idv, obs_req, obs_pop, obs_acc, obs_mis, obs_redir;
   logic [15:0] obs_pc, obs_ins, obs_addr;
   logic [15:0] exp_pc, exp_ins, exp_addr;
   bit          exp_mis, exp_halt;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return 16'(a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   task automatic model_clear();
      mq_addr.delete();
      mq_due.delete();
      m_id_pc       = C_RESET_PC;
      m_fetch       = C_RESET_PC;
      m_mis_pc      = 16'h0000;
      m_mis_pending = 1'b0;
      m_halt        = 1'b0;
      last_due      = cyc;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 16'h0000;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      id_ready       = 1'b0;
      #2 reset = 1'b1;
      model_clear();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // One clock cycle: drive inputs at the falling edge, sample just after, advance the model.
   task automatic step(input bit redir, input logic [15:0] rpc, input bit idr, input bit rqr,
                       input int lat);
      int due;
      @(negedge clk);
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mq_addr[0]);
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 16'($urandom);
      end
      redirect_valid = redir;
      redirect_pc    = rpc;
      id_ready       = idr;
      imem_req_ready = rqr;
      #1;
      obs_redir = redir;
      obs_idv   = id_valid;
      obs_req   = imem_req_valid;
      obs_pop   = !redir && id_valid && idr;
      obs_pc    = id_pc;
      obs_ins   = id_instruction;
      obs_acc   = imem_req_valid && rqr;
      obs_addr  = imem_addr;
`ifdef FETCH_ALIGN_CHECK_EN
      obs_mis   = id_misalign;
`else
      obs_mis   = 1'b0;
`endif
      exp_addr = m_fetch;
      exp_halt = m_halt;
      if (m_mis_pending) begin
         exp_pc  = m_mis_pc;
         exp_ins = 16'h0000;
         exp_mis = 1'b1;
      end else begin
         exp_pc  = m_id_pc;
         exp_ins = mem_word(m_id_pc);
         exp_mis = 1'b0;
      end
      if (redir) begin
         m_id_pc       = rpc & 16'hFFFE;
         m_fetch       = rpc & 16'hFFFE;
         m_mis_pending = 1'b0;
         m_halt        = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         if (rpc[0]) begin
            m_mis_pending = 1'b1;
            m_halt        = 1'b1;
            m_mis_pc      = rpc;
         end
`endif
      end else begin
         if (obs_acc) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(imem_addr);
            mq_due.push_back(due);
            m_fetch = m_fetch + 16'd2;
         end
         if (obs_pop) begin
            if (m_mis_pending) m_mis_pending = 1'b0;
            else               m_id_pc = m_id_pc + 16'd2;
         end
      end
      cyc++;
   endtask

   task automatic test_reset();
      apply_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1, 1'b1, 2);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_addr !== C_RESET_PC ||
          id_pc !== 16'h0000 || id_instruction !== 16'h0000)
         $display("FAIL reset_async: got idv=%b reqv=%b addr=%h pc=%h ins=%h, want 0 0 %h 0000 0000",
                  id_valid, imem_req_valid, imem_addr, id_pc, id_instruction, C_RESET_PC);
      else n_pass++;
      id_ready       = 1'b0;
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      model_clear();
      @(posedge clk); #1;
      n_checks++;
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b0)
         $display("FAIL reset_hold: got reqv=%b idv=%b, want 0 0", imem_req_valid, id_valid);
      else n_pass++;
      @(negedge clk); reset = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== C_RESET_PC)
         $display("FAIL reset_first_req: got reqv=%b addr=%h, want 1 %h",
                  imem_req_valid, imem_addr, C_RESET_PC);
      else n_pass++;
   endtask

   task automatic test_stream();
      int pops = 0;
      apply_reset();
      for (int i = 0; i < 24; i++) begin
         step(1'b0, 16'h0, 1'b1, 1'b1, 1);
         if (obs_pop) begin
            pops++;
            n_checks++;
            if (obs_pc !== exp_pc || obs_ins !== exp_ins || obs_mis !== exp_mis)
               $display("FAIL stream_id: got pc=%h ins=%h mis=%b, want pc=%h ins=%h mis=%b",
                        obs_pc, obs_ins, obs_mis, exp_pc, exp_ins, exp_mis);
            else n_pass++;
         end
         if (obs_acc) begin
            n_checks++;
            if (obs_addr !== exp_addr)
               $display("FAIL stream_req: got addr=%h, want %h", obs_addr, exp_addr);
            else n_pass++;
         end
      end
      n_checks++;
      if (pops < 10) $display("FAIL stream_rate: got %0d instructions, want >= 10", pops);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int accs = 0;
      int pops = 0;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 16'h0, 1'b0, 1'b1, 1);
         if (obs_acc) accs++;
      end
      n_checks++;
      if (accs > 2 || accs == 0) $display("FAIL bp_requests: got %0d requests, want 1..2", accs);
      else n_pass++;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 16'h0, 1'b1, 1'b1, 1);
         if (i == 0) begin
            n_checks++;
            if (obs_idv !== 1'b1 || obs_pc !== C_RESET_PC)
               $display("FAIL bp_head: got idv=%b pc=%h, want 1 %h", obs_idv, obs_pc, C_RESET_PC);
            else n_pass++;
         end
         if (obs_pop) begin
            pops++;
            n_checks++;
            if (obs_pc !== exp_pc || obs_ins !== exp_ins)
               $display("FAIL bp_order: got pc=%h ins=%h, want pc=%h ins=%h",
                        obs_pc, obs_ins, exp_pc, exp_ins);
            else n_pass++;
         end
         if (obs_acc) begin
            n_checks++;
            if (obs_addr !== exp_addr) $display("FAIL bp_req: got addr=%h, want %h", obs_addr, exp_addr);
            else n_pass++;
         end
      end
      n_checks++;
      if (pops < 4) $display("FAIL bp_drain: got %0d instructions, want >= 4", pops);
      else n_pass++;
   endtask

   task automatic test_redirect();
      bit          first = 1'b1;
      logic [15:0] first_pc = 16'h0;
      apply_reset();
      for (int i = 0; i < 10 && mq_addr.size() < 2; i++) step(1'b0, 16'h0, 1'b1, 1'b1, 3);
      n_checks++;
      if (mq_addr.size() != 2) $display("FAIL redir_inflight: got %0d pending, want 2", mq_addr.size());
      else n_pass++;
      step(1'b1, 16'h0200, 1'b1, 1'b1, 3);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 16'h0, 1'b1, 1'b1, 3);
         if (i == 0) begin
            n_checks++;
            if (obs_idv !== 1'b0) $display("FAIL redir_flush: got idv=%b, want 0", obs_idv);
            else n_pass++;
         end
         if (obs_pop) begin
            if (first) begin first = 1'b0; first_pc = obs_pc; end
            n_checks++;
            if (obs_pc !== exp_pc || obs_ins !== exp_ins)
               $display("FAIL redir_id: got pc=%h ins=%h, want pc=%h ins=%h",
                        obs_pc, obs_ins, exp_pc, exp_ins);
            else n_pass++;
         end
         if (obs_acc) begin
            n_checks++;
            if (obs_addr !== exp_addr) $display("FAIL redir_req: got addr=%h, want %h", obs_addr, exp_addr);
            else n_pass++;
         end
      end
      n_checks++;
      if (first || first_pc !== 16'h0200)
         $display("FAIL redir_target: got first pc=%h (seen=%b), want 0200", first_pc, !first);
      else n_pass++;
   endtask

   task automatic test_wrap();
      bit          saw_wrap = 1'b0;
      logic [15:0] prev = 16'h0;
      apply_reset();
      step(1'b1, 16'hFFFC, 1'b1, 1'b1, 1);
      for (int i = 0; i < 14; i++) begin
         step(1'b0, 16'h0, 1'b1, 1'b1, 1);
         if (obs_acc) begin
            if (prev == 16'hFFFE && obs_addr == 16'h0000) saw_wrap = 1'b1;
            prev = obs_addr;
            n_checks++;
            if (obs_addr !== exp_addr) $display("FAIL wrap_req: got addr=%h, want %h", obs_addr, exp_addr);
            else n_pass++;
         end
         if (obs_pop) begin
            n_checks++;
            if (obs_pc !== exp_pc || obs_ins !== exp_ins)
               $display("FAIL wrap_id: got pc=%h ins=%h, want pc=%h ins=%h",
                        obs_pc, obs_ins, exp_pc, exp_ins);
            else n_pass++;
         end
      end
      n_checks++;
      if (!saw_wrap) $display("FAIL wrap_seen: got no FFFE->0000 fetch, want one");
      else n_pass++;
   endtask

   task automatic test_req_stall();
      logic [15:0] held = 16'h0;
      apply_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, 1'b1, 2);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 16'h0, 1'b1, 1'b0, 2);
         if (i == 0) held = obs_addr;
         n_checks++;
         if (obs_addr !== exp_addr || obs_addr !== held)
            $display("FAIL stall_addr: got addr=%h, want %h (held %h)", obs_addr, exp_addr, held);
         else n_pass++;
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 16'h0, 1'b1, 1'b1, 2);
         if (obs_acc) begin
            n_checks++;
            if (obs_addr !== exp_addr) $display("FAIL stall_req: got addr=%h, want %h", obs_addr, exp_addr);
            else n_pass++;
         end
         if (obs_pop) begin
            n_checks++;
            if (obs_pc !== exp_pc || obs_ins !== exp_ins)
               $display("FAIL stall_id: got pc=%h ins=%h, want pc=%h ins=%h",
                        obs_pc, obs_ins, exp_pc, exp_ins);
            else n_pass++;
         end
      end
   endtask

`ifdef FETCH_ALIGN_CHECK_EN
   task automatic test_misalign();
      int pops = 0;
      apply_reset();
      for (int i = 0; i < 2; i++) step(1'b0, 16'h0, 1'b1, 1'b1, 3);
      step(1'b1, 16'h0301, 1'b0, 1'b1, 3);
      step(1'b0, 16'h0, 1'b0, 1'b1, 3);
      n_checks++;
      if (obs_idv !== 1'b1 || obs_pc !== 16'h0301 || obs_ins !== 16'h0000 || obs_mis !== 1'b1 || obs_req)
         $display("FAIL mis_entry: got idv=%b pc=%h ins=%h mis=%b reqv=%b, want 1 0301 0000 1 0",
                  obs_idv, obs_pc, obs_ins, obs_mis, obs_req);
      else n_pass++;
      step(1'b0, 16'h0, 1'b1, 1'b1, 3);
      n_checks++;
      if (!obs_pop || obs_pc !== exp_pc || obs_mis !== exp_mis)
         $display("FAIL mis_pop: got pop=%b pc=%h mis=%b, want 1 %h %b", obs_pop, obs_pc, obs_mis, exp_pc, exp_mis);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 16'h0, 1'b1, 1'b1, 3);
         n_checks++;
         if (obs_idv !== 1'b0 || obs_req !== 1'b0)
            $display("FAIL mis_halt: got idv=%b reqv=%b, want 0 0", obs_idv, obs_req);
         else n_pass++;
      end
      step(1'b1, 16'h0400, 1'b1, 1'b1, 3);
      for (int i = 0; i < 14; i++) begin
         step(1'b0, 16'h0, 1'b1, 1'b1, 3);
         if (obs_pop) begin
            pops++;
            n_checks++;
            if (obs_pc !== exp_pc || obs_ins !== exp_ins || obs_mis !== 1'b0)
               $display("FAIL mis_resume: got pc=%h ins=%h mis=%b, want pc=%h ins=%h mis=0",
                        obs_pc, obs_ins, obs_mis, exp_pc, exp_ins);
            else n_pass++;
         end
      end
      n_checks++;
      if (pops == 0) $display("FAIL mis_resume_none: got 0 instructions, want > 0");
      else n_pass++;
   endtask
`endif

   task automatic test_random();
      bit          redir;
      logic [15:0] rpc;
      for (int i = 0; i < 600; i++) begin
         redir = ($urandom_range(0, 19) == 0);
         rpc   = ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom);
`ifdef FETCH_ALIGN_CHECK_EN
         rpc   = rpc & 16'hFFFE;
`endif
         step(redir, rpc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
              int'($urandom_range(1, 4)));
         if (obs_pop) begin
            n_checks++;
            if (obs_pc !== exp_pc || obs_ins !== exp_ins || obs_mis !== exp_mis)
               $display("FAIL rand_id: got pc=%h ins=%h mis=%b, want pc=%h ins=%h mis=%b",
                        obs_pc, obs_ins, obs_mis, exp_pc, exp_ins, exp_mis);
            else n_pass++;
         end
         if (obs_acc) begin
            n_checks++;
            if (obs_addr !== exp_addr || obs_redir || exp_halt)
               $display("FAIL rand_req: got addr=%h redir=%b, want addr=%h and no request on redirect",
                        obs_addr, obs_redir, exp_addr);
            else n_pass++;
         end
      end
   endtask

   initial begin
      reset          = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 16'h0000;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      id_ready       = 1'b0;
      model_clear();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_req_stall();
`ifdef FETCH_ALIGN_CHECK_EN
      test_misalign();
`endif
      apply_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
